// File: rtl/uvmt_cv32e40x_sl_obi_pkg.sv
// Shared types for the OBI support-logic phase tracker.
package uvmt_cv32e40x_sl_obi_pkg;

  typedef enum logic {
    OBI_APH_IDLE,
    OBI_APH_WAIT
  } obi_aph_state_e;

endpackage

// File: rtl/uvmt_cv32e40x_sl_obi_phase_tracker.sv
// Passive OBI port monitor: address/response handshake strobes, in-flight count,
// gnt wait counter and protocol error flags for downstream assertions.
module uvmt_cv32e40x_sl_obi_phase_tracker
  import uvmt_cv32e40x_sl_obi_pkg::*;
#(
  parameter int ATTR_W          = 1,
  parameter int MAX_OUTSTANDING = 2,
  parameter int WAIT_W          = 8,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              obi_req_i,
  input  logic              obi_gnt_i,
  input  logic              obi_rvalid_i,
  input  logic [ATTR_W-1:0] obi_attr_i,
  output logic              req_fire_o,
  output logic              rsp_fire_o,
  output logic [ATTR_W-1:0] attr_o,
  output logic [CNT_W-1:0]  outstanding_o,
  output logic [WAIT_W-1:0] wait_cycles_o,
  output logic              err_unstable_o,
  output logic              err_overflow_o,
  output logic              err_underflow_o,
  output logic              err_sticky_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  obi_aph_state_e    state_q, state_d;
  logic [ATTR_W-1:0] attr_q;
  logic [CNT_W-1:0]  cnt_d;

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (&v) ? v : v + WAIT_W'(1);
  endfunction

  assign req_fire_o      = obi_req_i && obi_gnt_i;
  // An rvalid with nothing in flight is an error, never a valid response.
  assign rsp_fire_o      = obi_rvalid_i && (outstanding_o != '0);
  assign attr_o          = req_fire_o ? obi_attr_i : '0;
  assign err_underflow_o = obi_rvalid_i && (outstanding_o == '0);
  assign err_overflow_o  = req_fire_o && !rsp_fire_o && (outstanding_o == MAX_CNT);

  always_comb begin
    state_d        = state_q;
    err_unstable_o = 1'b0;
    case (state_q)
      OBI_APH_IDLE: begin
        if (obi_req_i && !obi_gnt_i) state_d = OBI_APH_WAIT;
      end
      OBI_APH_WAIT: begin
        if (!obi_req_i) begin
          state_d        = OBI_APH_IDLE;
          err_unstable_o = 1'b1;
        end else begin
          if (obi_gnt_i) state_d = OBI_APH_IDLE;
          if (obi_attr_i != attr_q) err_unstable_o = 1'b1;
        end
      end
      default: state_d = OBI_APH_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= OBI_APH_IDLE;
      attr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == OBI_APH_IDLE && state_d == OBI_APH_WAIT) attr_q <= obi_attr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cycles_o <= '0;
    end else if (state_d == OBI_APH_WAIT) begin
      wait_cycles_o <= (state_q == OBI_APH_WAIT) ? sat_inc(wait_cycles_o) : WAIT_W'(1);
    end else begin
      wait_cycles_o <= '0;
    end
  end

  // A grant at full capacity is flagged and dropped; the count never exceeds MAX.
  always_comb begin
    cnt_d = outstanding_o;
    if (req_fire_o && !rsp_fire_o && outstanding_o != MAX_CNT) cnt_d = outstanding_o + CNT_W'(1);
    else if (rsp_fire_o && !req_fire_o)                         cnt_d = outstanding_o - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) outstanding_o <= '0;
    else         outstanding_o <= cnt_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_sticky_o <= 1'b0;
    else         err_sticky_o <= err_sticky_o | err_unstable_o | err_overflow_o | err_underflow_o;
  end

endmodule

// File: tb/tb_uvmt_cv32e40x_sl_obi_phase_tracker.sv
// Scoreboard bench for the OBI phase tracker: driver pushes model predictions, monitor compares.
module tb_uvmt_cv32e40x_sl_obi_phase_tracker;

  localparam int MAXO = 2;
  localparam int WMAX = 255;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       req = 1'b0, gnt = 1'b0, rvalid = 1'b0;
  logic [0:0] attr = 1'b0;
  logic       req_fire, rsp_fire;
  logic [0:0] attr_out;
  logic [1:0] outstanding;
  logic [7:0] wait_cycles;
  logic       e_unst, e_ovf, e_udf, e_sticky;

  uvmt_cv32e40x_sl_obi_phase_tracker #(.ATTR_W(1), .MAX_OUTSTANDING(MAXO), .WAIT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .obi_req_i(req), .obi_gnt_i(gnt), .obi_rvalid_i(rvalid),
    .obi_attr_i(attr), .req_fire_o(req_fire), .rsp_fire_o(rsp_fire), .attr_o(attr_out),
    .outstanding_o(outstanding), .wait_cycles_o(wait_cycles), .err_unstable_o(e_unst),
    .err_overflow_o(e_ovf), .err_underflow_o(e_udf), .err_sticky_o(e_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rf, sf, at, outst, wt, eu, eo, ud, es;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: in-flight count, wait age of the pending request, captured attr.
  int m_out = 0, m_wait = 0, m_pending = 0, m_cap = 0, m_sticky = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit g, input bit rv, input bit a, input bit rst_n);
    exp_t e;
    @(negedge clk);
    rst_ni = rst_n; req = r; gnt = g; rvalid = rv; attr = a;
    if (!rst_n) begin
      m_out = 0; m_wait = 0; m_pending = 0; m_cap = 0; m_sticky = 0;
    end
    e.rf    = r && g;
    e.sf    = rv && (m_out > 0);
    e.at    = e.rf ? a : 0;
    e.eu    = m_pending && (!r || a != m_cap);
    e.eo    = e.rf && !e.sf && (m_out == MAXO);
    e.ud    = rv && (m_out == 0);
    e.outst = m_out;
    e.wt    = m_wait;
    e.es    = m_sticky;
    exp_q.push_back(e);
    if (rst_n) begin
      m_out = m_out + e.rf - e.sf;
      if (m_out > MAXO) m_out = MAXO;
      if (r && !g) begin
        if (m_pending) m_wait = (m_wait < WMAX) ? m_wait + 1 : WMAX;
        else begin m_wait = 1; m_cap = a; end
        m_pending = 1;
      end else begin
        m_wait = 0; m_pending = 0;
      end
      if (e.eu || e.eo || e.ud) m_sticky = 1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("req_fire",    int'(req_fire),    e.rf);
      chk("rsp_fire",    int'(rsp_fire),    e.sf);
      chk("attr",        int'(attr_out),    e.at);
      chk("outstanding", int'(outstanding), e.outst);
      chk("wait_cycles", int'(wait_cycles), e.wt);
      chk("err_unstable",  int'(e_unst),    e.eu);
      chk("err_overflow",  int'(e_ovf),     e.eo);
      chk("err_underflow", int'(e_udf),     e.ud);
      chk("err_sticky",    int'(e_sticky),  e.es);
    end
  end

  initial begin
    // Reset
    cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 1, 1, 0);
    cycle(0, 0, 0, 0, 1);
    // Single transaction, response two cycles later
    cycle(1, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 1);
    cycle(0, 0, 0, 0, 1);
    // Request waits three cycles for gnt, attr held at 1
    cycle(1, 0, 0, 1, 1);
    cycle(1, 0, 0, 1, 1);
    cycle(1, 0, 0, 1, 1);
    cycle(1, 1, 0, 1, 1);
    cycle(0, 0, 1, 0, 1);
    cycle(0, 0, 0, 0, 1);
    // Outstanding 1 with simultaneous grant and response
    cycle(1, 1, 0, 0, 1);
    cycle(1, 1, 1, 0, 1);
    cycle(0, 0, 1, 0, 1);
    cycle(0, 0, 0, 0, 1);
    // Wait counter saturation
    for (int i = 0; i < 260; i++) cycle(1, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 1);
    cycle(0, 0, 1, 0, 1);
    // Retracted request
    cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    // Attr change during wait, including on the gnt cycle
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 1, 1);
    cycle(1, 1, 0, 1, 1);
    cycle(0, 0, 1, 0, 1);
    // Overflow: three grants with no response
    cycle(1, 1, 0, 0, 1);
    cycle(1, 1, 0, 0, 1);
    cycle(1, 1, 0, 1, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 1);
    cycle(0, 0, 1, 0, 1);
    // Underflow, alone and alongside a grant
    cycle(0, 0, 1, 0, 1);
    cycle(1, 1, 1, 0, 1);
    cycle(0, 0, 0, 0, 1);
    // Reset in the middle of a burst
    cycle(1, 1, 0, 0, 1);
    cycle(1, 0, 0, 1, 1);
    cycle(1, 0, 0, 1, 0);
    cycle(0, 0, 1, 0, 1);
    cycle(0, 0, 0, 0, 1);
    // Random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 199) != 0));
    end
    cycle(0, 0, 0, 0, 1);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
